s2_scan_accum: RTL and testbench

Scan controller and accumulator wrapped around the registered 4:1 mux stage S2. It drives S2's select inputs (A1, B1, A0, B0) to step through D00, D01, D10 and D11, and captures each value from S2's `out`. It produces the 4-sample sum and the maximum with a valid/ack handshake. The block sits directly upstream of S2 on the select side and directly downstream of it on the data side.

---
 rtl/s2_scan_accum_pkg.sv | 27 ++
 rtl/s2_scan_accum_if.sv | 32 +++
 rtl/s2_scan_accum_sel_decode.sv | 14 +
 rtl/s2_scan_accum.sv | 100 ++++++++++
 tb/tb_s2_scan_accum.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/s2_scan_accum_pkg.sv
// Shared types and constants for the S2 scan/accumulate controller.
// Select codes are packed as {A1, B1, A0, B0} and indexed by the scan position k.
package s2_scan_pkg;

  localparam int SIZE_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    CAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Row = A1|B1, column = A0&B0; B1 is never used to select a row.
  localparam logic [3:0] SEL_CODE [0:3] = '{
    4'b0000,  // k=0 -> D00
    4'b0011,  // k=1 -> D01
    4'b1000,  // k=2 -> D10
    4'b1011   // k=3 -> D11
  };

  // Four unsigned size-bit samples need two extra bits of headroom.
  function automatic int sumw_of(input int size);
    return size + 2;
  endfunction

endpackage

// File: rtl/s2_scan_accum_if.sv
// Select, data and result/handshake signals between the scan controller and its environment.
// The slave modport is the controller; the master modport is S2 plus the result consumer.
interface s2_scan_accum_if
  import s2_scan_pkg::*;
#(
  parameter int size = SIZE_DEFAULT,
  parameter int SUMW = sumw_of(size)
);

  logic            start;
  logic            res_ack;
  logic [size-1:0] s2_out;
  logic            A1;
  logic            B1;
  logic            A0;
  logic            B0;
  logic            busy;
  logic            res_valid;
  logic [SUMW-1:0] sum;
  logic [size-1:0] max;

  modport slave (
    input  start, res_ack, s2_out,
    output A1, B1, A0, B0, busy, res_valid, sum, max
  );

  modport master (
    output start, res_ack, s2_out,
    input  A1, B1, A0, B0, busy, res_valid, sum, max
  );

endinterface

// File: rtl/s2_scan_accum_sel_decode.sv
// Combinational decode of the scan index k into S2's four select lines.
module s2_sel_decode
  import s2_scan_pkg::*;
(
  input  logic [1:0] k_i,
  output logic       a1_o,
  output logic       b1_o,
  output logic       a0_o,
  output logic       b0_o
);

  assign {a1_o, b1_o, a0_o, b0_o} = SEL_CODE[k_i];

endmodule

// File: rtl/s2_scan_accum.sv
// Steps S2 through D00, D01, D10, D11 (two cycles per code), accumulating the
// sum and maximum of the captured samples and holding them under valid/ack.
module s2_scan_accum
  import s2_scan_pkg::*;
#(
  parameter int size = SIZE_DEFAULT,
  parameter int SUMW = sumw_of(size)
) (
  input  logic            clk,
  input  logic            CLR,
  s2_scan_accum_if.slave  bus
);

  state_e          state_q;
  logic [1:0]      k_q;
  logic [SUMW-1:0] sum_q;
  logic [size-1:0] max_q;
  logic            busy_q;
  logic            valid_q;

  // k_q is forced to 0 outside SET/CAP, so the decoder alone yields the idle code.
  s2_sel_decode u_sel_decode (
    .k_i  (k_q),
    .a1_o (bus.A1),
    .b1_o (bus.B1),
    .a0_o (bus.A0),
    .b0_o (bus.B0)
  );

  // NOTE: every register here uses <= so all next-state values come from the
  // pre-edge state; a blocking = would let later statements see updated values.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      sum_q   <= '0;
      max_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= SET;
            k_q     <= 2'd0;
            sum_q   <= '0;
            max_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        SET: begin
          state_q <= CAP;
        end

        CAP: begin
          sum_q <= sum_q + SUMW'(bus.s2_out);
          // Strict compare: an equal sample leaves the stored maximum alone.
          if (bus.s2_out > max_q) begin
            max_q <= bus.s2_out;
          end
          if (k_q == 2'd3) begin
            state_q <= DONE;
            k_q     <= 2'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            state_q <= SET;
            k_q     <= k_q + 2'd1;
          end
        end

        DONE: begin
          if (bus.res_ack) begin
            valid_q <= 1'b0;
            if (bus.start) begin
              state_q <= SET;
              k_q     <= 2'd0;
              sum_q   <= '0;
              max_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.sum       = sum_q;
  assign bus.max       = max_q;

endmodule

// File: tb/tb_s2_scan_accum.sv
// Directed bench for s2_scan_accum driving a behavioural registered S2 mux.
module tb_s2_scan_accum;

  localparam int SIZE = 5;
  localparam int SUMW = SIZE + 2;

  logic clk;
  logic CLR;
  logic [SIZE-1:0] d00, d01, d10, d11;

  int total;
  int bad;

  logic [3:0] exp_code [0:3];

  s2_scan_accum_if #(.size(SIZE), .SUMW(SUMW)) bus ();

  s2_scan_accum #(.size(SIZE), .SUMW(SUMW)) dut (
    .clk (clk),
    .CLR (CLR),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S2: registered 4:1 mux, row = A1|B1, column = A0&B0.
  always @(posedge clk) begin
    case ({bus.A1 | bus.B1, bus.A0 & bus.B0})
      2'b00:   bus.s2_out <= d00;
      2'b01:   bus.s2_out <= d01;
      2'b10:   bus.s2_out <= d10;
      default: bus.s2_out <= d11;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [SIZE-1:0] a, b, c, d);
    d00 = a; d01 = b; d10 = c; d11 = d;
  endtask

  // Called just after the edge that launched a scan; checks the 8 scan cycles
  // and the result at E0+8. poke_at >= 0 pulses start during that scan cycle.
  task automatic check_scan(input string name, input logic [SUMW-1:0] exp_sum,
                            input logic [SIZE-1:0] exp_max, input int poke_at);
    logic [3:0] sel;
    for (int i = 0; i < 8; i++) begin
      sel = {bus.A1, bus.B1, bus.A0, bus.B0};
      total++;
      if (sel !== exp_code[i/2] || bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s cyc%0d: sel=%b busy=%b valid=%b, want sel=%b busy=1 valid=0",
                 name, i, sel, bus.busy, bus.res_valid, exp_code[i/2]);
      end
      if (i == poke_at) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    sel = {bus.A1, bus.B1, bus.A0, bus.B0};
    total++;
    if (bus.res_valid !== 1'b1 || bus.busy !== 1'b0 || sel !== 4'b0000) begin
      bad++;
      $display("FAIL %s done: valid=%b busy=%b sel=%b, want valid=1 busy=0 sel=0000",
               name, bus.res_valid, bus.busy, sel);
    end
    total++;
    if (bus.sum !== exp_sum) begin
      bad++;
      $display("FAIL %s sum: got %0d want %0d", name, bus.sum, exp_sum);
    end
    total++;
    if (bus.max !== exp_max) begin
      bad++;
      $display("FAIL %s max: got %0d want %0d", name, bus.max, exp_max);
    end
  endtask

  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic ack(input string name);
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    total++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s ack: valid=%b busy=%b, want 0 0", name, bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.A1, bus.B1, bus.A0, bus.B0, bus.busy, bus.res_valid} !== 6'b0 ||
        bus.sum !== '0 || bus.max !== '0) begin
      bad++;
      $display("FAIL reset: sel=%b busy=%b valid=%b sum=%0d max=%0d, want all 0",
               {bus.A1, bus.B1, bus.A0, bus.B0}, bus.busy, bus.res_valid, bus.sum, bus.max);
    end
  endtask

  task automatic test_basic();
    set_d(5'd3, 5'd7, 5'd31, 5'd0);
    launch();
    check_scan("basic", 7'd41, 5'd31, -1);
    ack("basic");
  endtask

  task automatic test_bounds();
    set_d(5'd31, 5'd31, 5'd31, 5'd31);
    launch();
    check_scan("all31", 7'd124, 5'd31, -1);
    ack("all31");
    set_d(5'd0, 5'd0, 5'd0, 5'd0);
    launch();
    check_scan("all0", 7'd0, 5'd0, -1);
    ack("all0");
  endtask

  task automatic test_hold();
    set_d(5'd5, 5'd6, 5'd7, 5'd8);
    launch();
    check_scan("hold", 7'd26, 5'd8, -1);
    for (int i = 0; i < 10; i++) begin
      set_d(5'(i), 5'(31 - i), 5'(i * 3), 5'd30);
      tick();
      total++;
      if (bus.res_valid !== 1'b1 || bus.sum !== 7'd26 || bus.max !== 5'd8) begin
        bad++;
        $display("FAIL hold cyc%0d: valid=%b sum=%0d max=%0d, want 1 26 8",
                 i, bus.res_valid, bus.sum, bus.max);
      end
    end
    ack("hold");
    tick();
    total++;
    if (bus.busy !== 1'b0 || {bus.A1, bus.B1, bus.A0, bus.B0} !== 4'b0000) begin
      bad++;
      $display("FAIL hold idle: busy=%b sel=%b, want 0 0000",
               bus.busy, {bus.A1, bus.B1, bus.A0, bus.B0});
    end
  endtask

  task automatic test_back_to_back();
    set_d(5'd3, 5'd7, 5'd31, 5'd0);
    launch();
    check_scan("b2b_first", 7'd41, 5'd31, -1);
    set_d(5'd1, 5'd2, 5'd3, 5'd4);
    bus.res_ack = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    bus.start   = 1'b0;
    check_scan("b2b_second", 7'd10, 5'd4, -1);
    ack("b2b");
  endtask

  task automatic test_reset_mid_scan();
    set_d(5'd3, 5'd7, 5'd31, 5'd0);
    launch();
    repeat (5) tick();
    total++;
    if ({bus.A1, bus.B1, bus.A0, bus.B0} !== 4'b1000 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst pre: sel=%b busy=%b, want 1000 1",
               {bus.A1, bus.B1, bus.A0, bus.B0}, bus.busy);
    end
    #2 CLR = 1'b0;
    #1;
    test_reset();
    #3 CLR = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || {bus.A1, bus.B1, bus.A0, bus.B0} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst idle: busy=%b valid=%b sel=%b, want 0 0 0000",
               bus.busy, bus.res_valid, {bus.A1, bus.B1, bus.A0, bus.B0});
    end
    set_d(5'd1, 5'd2, 5'd3, 5'd4);
    launch();
    check_scan("midrst_rescan", 7'd10, 5'd4, -1);
    ack("midrst");
  endtask

  task automatic test_start_while_busy();
    set_d(5'd2, 5'd4, 5'd6, 5'd8);
    launch();
    // Scan cycle 2 is SET with k=1.
    check_scan("busy_start", 7'd20, 5'd8, 2);
    ack("busy_start");
    repeat (3) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_start extra scan: busy=%b valid=%b, want 0 0", bus.busy, bus.res_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_code[0] = 4'b0000;
    exp_code[1] = 4'b0011;
    exp_code[2] = 4'b1000;
    exp_code[3] = 4'b1011;
    CLR         = 1'b0;
    bus.start   = 1'b0;
    bus.res_ack = 1'b0;
    set_d(5'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) tick();
    test_reset();
    CLR = 1'b1;
    repeat (2) tick();
    test_basic();
    test_bounds();
    test_hold();
    test_back_to_back();
    test_reset_mid_scan();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
